// File: rtl/rw_stream_bridge.sv
// rtl/rw_stream_bridge.sv - host byte-stream bridge with input/output FIFOs for single-byte ReWire devices
module rw_stream_bridge #(
  parameter int          DEPTH     = 8,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic [7:0]  dev_in,
  input  logic [7:0]  dev_out,
  output logic        dev_rst,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic [15:0] step_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_DEVRST = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t state, state_next;
  logic   devrst_cnt, devrst_cnt_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] in_wr, in_rd, out_wr, out_rd;
  logic [7:0]  in_mem  [DEPTH];
  logic [7:0]  out_mem [DEPTH];
  logic [15:0] step_cnt;

  logic in_empty, in_full, out_empty, out_full;
  logic run, flush_now, push_in, pop_out, step;

  assign in_empty  = (in_wr == in_rd);
  assign in_full   = (in_wr[AW-1:0] == in_rd[AW-1:0]) && (in_wr[AW] != in_rd[AW]);
  assign out_empty = (out_wr == out_rd);
  assign out_full  = (out_wr[AW-1:0] == out_rd[AW-1:0]) && (out_wr[AW] != out_rd[AW]);

  // Controller next-state and handshake/step decode.
  always_comb begin
    state_next      = state;
    devrst_cnt_next = devrst_cnt;
    run             = 1'b0;
    flush_now       = 1'b0;
    case (state)
      ST_RESET: begin
        state_next      = ST_DEVRST;
        devrst_cnt_next = 1'b0;
      end
      ST_DEVRST: begin
        if (devrst_cnt) begin
          state_next = ST_RUN;
        end else begin
          devrst_cnt_next = 1'b1;
        end
      end
      ST_RUN: begin
        run = 1'b1;
        if (flush) begin
          flush_now       = 1'b1;
          state_next      = ST_DEVRST;
          devrst_cnt_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  // A flush cycle discards any handshake and suppresses the step.
  assign s_ready = run && !in_full;
  assign m_valid = run && !out_empty;
  assign push_in = s_valid && s_ready && !flush_now;
  assign pop_out = m_valid && m_ready && !flush_now;
  assign step    = run && !flush_now && !in_empty && (!out_full || pop_out);

  assign dev_rst    = (state != ST_RUN);
  assign dev_in     = step ? in_mem[in_rd[AW-1:0]] : IDLE_BYTE;
  assign m_data     = out_empty ? 8'h00 : out_mem[out_rd[AW-1:0]];
  assign step_count = step_cnt;

  // Controller state register; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RESET;
      devrst_cnt <= 1'b0;
    end else begin
      state      <= state_next;
      devrst_cnt <= devrst_cnt_next;
    end
  end

  // FIFO pointers; flush and rst both empty the FIFOs.
  always_ff @(posedge clk) begin
    if (rst || flush_now) begin
      in_wr  <= '0;
      in_rd  <= '0;
      out_wr <= '0;
      out_rd <= '0;
    end else begin
      if (push_in) in_wr  <= in_wr + (AW+1)'(1);
      if (step)    in_rd  <= in_rd + (AW+1)'(1);
      if (step)    out_wr <= out_wr + (AW+1)'(1);
      if (pop_out) out_rd <= out_rd + (AW+1)'(1);
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_in) in_mem[in_wr[AW-1:0]]   <= s_data;
    if (step)    out_mem[out_wr[AW-1:0]] <= dev_out;
  end

  // Completed-step counter; survives flush, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= 16'h0000;
    end else if (step) begin
      step_cnt <= step_cnt + 16'h0001;
    end
  end

endmodule
